// File: rtl/parking_gate_scheduler.sv
// Shared barrier gate sequencer: arbitrates entry/exit requests, times the
// open gate and tracks parking occupancy.
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   entReq, exitReq   level requests (entry password already accepted)
//   carPassed         one-cycle pulse, car cleared the gate
//   gateOpen          gate open command
//   entGrant          one-cycle pulse on the first entry open cycle
//   exitGrant         one-cycle pulse on the first exit open cycle
//   dirExit           direction of current/last service (1 = exit)
//   occupancy         cars currently parked
//   full, empty       occupancy == CAPACITY / occupancy == 0
//   timeoutErr        one-cycle pulse, gate closed with no car passing
//
// Optional feature macro: PARK_RR_EN (round-robin arbitration when both
// directions are eligible; otherwise exit always wins).
module parking_gate_scheduler #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = 16,
    parameter int TIMER_W     = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             entReq,
    input  logic             exitReq,
    input  logic             carPassed,
    output logic             gateOpen,
    output logic             entGrant,
    output logic             exitGrant,
    output logic             dirExit,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             timeoutErr
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_OPEN_ENT  = 2'd1;
    localparam logic [1:0] S_OPEN_EXIT = 2'd2;
    localparam logic [1:0] S_CLOSE     = 2'd3;

    localparam logic [CNT_W-1:0]   CAP_V   = CNT_W'(CAPACITY);
    localparam logic [TIMER_W-1:0] T_LAST  = TIMER_W'(OPEN_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               gate_open_q, gate_open_d;
    logic               ent_grant_q, ent_grant_d;
    logic               exit_grant_q, exit_grant_d;
    logic               dir_exit_q, dir_exit_d;
    logic [CNT_W-1:0]   occupancy_q, occupancy_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               timeout_err_q, timeout_err_d;

    logic ent_elig;
    logic exit_elig;
    logic pick_exit;

    assign ent_elig  = entReq && !full_q;
    assign exit_elig = exitReq && !empty_q;

    // dir_exit_q doubles as the last-served register.
    always_comb begin
        pick_exit = 1'b0;
        if (exit_elig && !ent_elig) begin
            pick_exit = 1'b1;
        end else if (exit_elig && ent_elig) begin
`ifdef PARK_RR_EN
            pick_exit = !dir_exit_q;
`else
            pick_exit = 1'b1;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        gate_open_d   = 1'b0;
        ent_grant_d   = 1'b0;
        exit_grant_d  = 1'b0;
        dir_exit_d    = dir_exit_q;
        occupancy_d   = occupancy_q;
        timeout_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ent_elig || exit_elig) begin
                    gate_open_d = 1'b1;
                    timer_d     = '0;
                    dir_exit_d  = pick_exit;
                    if (pick_exit) begin
                        state_d      = S_OPEN_EXIT;
                        exit_grant_d = 1'b1;
                    end else begin
                        state_d     = S_OPEN_ENT;
                        ent_grant_d = 1'b1;
                    end
                end
            end
            S_OPEN_ENT, S_OPEN_EXIT: begin
                // A pass on the timeout cycle wins over the timeout.
                if (carPassed) begin
                    state_d = S_CLOSE;
                    if (state_q == S_OPEN_ENT) begin
                        occupancy_d = occupancy_q + CNT_W'(1);
                    end else begin
                        occupancy_d = occupancy_q - CNT_W'(1);
                    end
                end else if (timer_q == T_LAST) begin
                    state_d       = S_CLOSE;
                    timeout_err_d = 1'b1;
                end else begin
                    gate_open_d = 1'b1;
                    timer_d     = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        full_d  = (occupancy_d == CAP_V);
        empty_d = (occupancy_d == '0);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            gate_open_q   <= 1'b0;
            ent_grant_q   <= 1'b0;
            exit_grant_q  <= 1'b0;
            dir_exit_q    <= 1'b0;
            occupancy_q   <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            gate_open_q   <= gate_open_d;
            ent_grant_q   <= ent_grant_d;
            exit_grant_q  <= exit_grant_d;
            dir_exit_q    <= dir_exit_d;
            occupancy_q   <= occupancy_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gateOpen   = gate_open_q;
    assign entGrant   = ent_grant_q;
    assign exitGrant  = exit_grant_q;
    assign dirExit    = dir_exit_q;
    assign occupancy  = occupancy_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed self-checking bench for parking_gate_scheduler
// (CAPACITY=2, OPEN_CYCLES=4).
module tb_parking_gate_scheduler;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       entReq = 1'b0;
    logic       exitReq = 1'b0;
    logic       carPassed = 1'b0;
    logic       gateOpen;
    logic       entGrant;
    logic       exitGrant;
    logic       dirExit;
    logic [3:0] occupancy;
    logic       full;
    logic       empty;
    logic       timeoutErr;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    parking_gate_scheduler #(
        .CAPACITY(2),
        .CNT_W(4),
        .OPEN_CYCLES(4),
        .TIMER_W(8)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .entReq(entReq),
        .exitReq(exitReq),
        .carPassed(carPassed),
        .gateOpen(gateOpen),
        .entGrant(entGrant),
        .exitGrant(exitGrant),
        .dirExit(dirExit),
        .occupancy(occupancy),
        .full(full),
        .empty(empty),
        .timeoutErr(timeoutErr)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arbitration sequence starting at occupancy 1, last served = exit.
    logic exp_ex [3];
    logic [3:0] exp_oc [3];

    initial begin
`ifdef PARK_RR_EN
        exp_ex[0] = 1'b0; exp_oc[0] = 4'd2;
        exp_ex[1] = 1'b1; exp_oc[1] = 4'd1;
        exp_ex[2] = 1'b0; exp_oc[2] = 4'd2;
`else
        exp_ex[0] = 1'b1; exp_oc[0] = 4'd0;
        exp_ex[1] = 1'b0; exp_oc[1] = 4'd1;
        exp_ex[2] = 1'b1; exp_oc[2] = 4'd0;
`endif

        // Reset state
        tick();
        tick();
        Rst = 1'b0;
        check("rst_gate", 32'(gateOpen), 0);
        check("rst_entg", 32'(entGrant), 0);
        check("rst_exitg", 32'(exitGrant), 0);
        check("rst_dir", 32'(dirExit), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_tmo", 32'(timeoutErr), 0);

        // First entry, pass on 2nd open cycle
        entReq = 1'b1;
        tick();
        check("e1_gate", 32'(gateOpen), 1);
        check("e1_grant", 32'(entGrant), 1);
        check("e1_dir", 32'(dirExit), 0);
        entReq = 1'b0;
        tick();
        check("e1_gate2", 32'(gateOpen), 1);
        check("e1_grant2", 32'(entGrant), 0);
        carPassed = 1'b1;
        tick();
        carPassed = 1'b0;
        check("e1_close", 32'(gateOpen), 0);
        check("e1_occ", 32'(occupancy), 1);
        check("e1_empty", 32'(empty), 0);
        tick();

        // Second entry fills the lot
        entReq = 1'b1;
        tick();
        check("e2_grant", 32'(entGrant), 1);
        carPassed = 1'b1;
        tick();
        carPassed = 1'b0;
        check("e2_occ", 32'(occupancy), 2);
        check("e2_full", 32'(full), 1);
        // Third request held while full
        for (int i = 0; i < 20; i++) begin
            tick();
            check("full_entg", 32'(entGrant), 0);
            check("full_gate", 32'(gateOpen), 0);
        end
        entReq = 1'b0;

        // Exit with timeout: gate open exactly 4 cycles
        exitReq = 1'b1;
        tick();
        check("to_grant", 32'(exitGrant), 1);
        check("to_dir", 32'(dirExit), 1);
        check("to_gate1", 32'(gateOpen), 1);
        exitReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_gate", 32'(gateOpen), 1);
            check("to_early", 32'(timeoutErr), 0);
        end
        tick();
        check("to_closed", 32'(gateOpen), 0);
        check("to_err", 32'(timeoutErr), 1);
        check("to_occ", 32'(occupancy), 2);
        tick();
        check("to_pulse", 32'(timeoutErr), 0);

        // Exit with pass on the 4th (timeout) cycle
        exitReq = 1'b1;
        tick();
        check("lp_grant", 32'(exitGrant), 1);
        exitReq = 1'b0;
        tick();
        tick();
        tick();
        check("lp_gate4", 32'(gateOpen), 1);
        carPassed = 1'b1;
        tick();
        carPassed = 1'b0;
        check("lp_occ", 32'(occupancy), 1);
        check("lp_tmo", 32'(timeoutErr), 0);
        check("lp_gate", 32'(gateOpen), 0);
        check("lp_full", 32'(full), 0);
        tick();

        // carPassed in IDLE ignored
        carPassed = 1'b1;
        tick();
        carPassed = 1'b0;
        check("idle_occ", 32'(occupancy), 1);
        check("idle_gate", 32'(gateOpen), 0);
        tick();

        // Both requesting at occupancy 1, last served exit
        entReq  = 1'b1;
        exitReq = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("arb_exitg", 32'(exitGrant), 32'(exp_ex[s]));
            check("arb_entg", 32'(entGrant), 32'(!exp_ex[s]));
            carPassed = 1'b1;
            tick();
            carPassed = 1'b0;
            check("arb_occ", 32'(occupancy), 32'(exp_oc[s]));
            tick();
        end
        entReq  = 1'b0;
        exitReq = 1'b0;
        tick();

        // Reset mid-service at occupancy 1
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        entReq = 1'b1;
        tick();
        entReq = 1'b0;
        carPassed = 1'b1;
        tick();
        carPassed = 1'b0;
        check("mr_occ1", 32'(occupancy), 1);
        tick();
        entReq = 1'b1;
        tick();
        check("mr_open", 32'(gateOpen), 1);
        entReq = 1'b0;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("mr_gate", 32'(gateOpen), 0);
        check("mr_occ", 32'(occupancy), 0);
        check("mr_empty", 32'(empty), 1);
        check("mr_entg", 32'(entGrant), 0);
        check("mr_exitg", 32'(exitGrant), 0);
        check("mr_tmo", 32'(timeoutErr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
